// File: rtl/keypad_emulator_pkg.sv
// Shared keypad definitions: key-code constants, emulator FSM states and the
// key-code to (row, col) table used by both scanner and emulator.
package keypad_emulator_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_rc_t;

  // Codes 12-15 never reach the table in the emulator; they map to (0,0).
  function automatic key_rc_t key_to_rc(input logic [3:0] code);
    key_rc_t rc;
    rc = '0;
    case (code)
      4'd1:     rc = '{row: 2'd0, col: 2'd0};
      4'd2:     rc = '{row: 2'd0, col: 2'd1};
      4'd3:     rc = '{row: 2'd0, col: 2'd2};
      4'd4:     rc = '{row: 2'd1, col: 2'd0};
      4'd5:     rc = '{row: 2'd1, col: 2'd1};
      4'd6:     rc = '{row: 2'd1, col: 2'd2};
      4'd7:     rc = '{row: 2'd2, col: 2'd0};
      4'd8:     rc = '{row: 2'd2, col: 2'd1};
      4'd9:     rc = '{row: 2'd2, col: 2'd2};
      KEY_STAR: rc = '{row: 2'd3, col: 2'd0};
      4'd0:     rc = '{row: 2'd3, col: 2'd1};
      KEY_HASH: rc = '{row: 2'd3, col: 2'd2};
      default:  rc = '0;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_emu_fifo.sv
// Key-code queue: synchronous FIFO with wrap-around pointers carrying an
// extra MSB so full and empty are told apart without a counter.
module keypad_emu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/keypad_emulator.sv
// Keypad row-side emulator: replays queued key codes as timed presses on the
// row lines. Define KEYPAD_EMU_SYNC_EN for a 2-flop col synchronizer.
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int HOLD_CYCLES = 4096,
  parameter int GAP_CYCLES  = 4096,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       clear,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       err,
  output state_t     dbg_state
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = 1;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  krow;
  logic [1:0]  kcol;
  logic [2:0]  col_s;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  fifo_rd_data;
  logic        hs;
  logic        code_ok;
  logic        push;
  logic        pop;
  key_rc_t     rc;

  // Handshake: a code transfers when key_valid & key_ready are both high on a
  // rising edge; key_ready never depends on key_valid.
  assign key_ready = !fifo_full && !clear;
  assign hs        = key_valid && key_ready;
  assign code_ok   = (key_code <= KEY_HASH);
  assign push      = hs && code_ok;
  assign pop       = (state == IDLE) && !fifo_empty && !clear;
  assign rc        = key_to_rc(fifo_rd_data);
  assign busy      = !fifo_empty || (state != IDLE);
  assign dbg_state = state;

  keypad_emu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (clear),
    .wr_data (key_code),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef KEYPAD_EMU_SYNC_EN
  logic [2:0] col_meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '0;
      col_s    <= '0;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_s <= '0;
    else        col_s <= col;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      krow  <= '0;
      kcol  <= '0;
      row   <= '0;
      err   <= 1'b0;
    end else begin
      err <= hs && !code_ok;
      row <= ((state == PRESS) && col_s[kcol]) ? (4'b0001 << krow) : 4'b0000;
      if (clear) begin
        state <= IDLE;
        cnt   <= '0;
        row   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              krow  <= rc.row;
              kcol  <= rc.col;
              cnt   <= HOLD_LOAD;
              state <= PRESS;
            end
          end
          PRESS: begin
            if (cnt == '0) begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          GAP: begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - CNT_ONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
